// File: rtl/prefix_arith_pkg.sv
// Shared types and helpers for the prefix subtractor:
// group (g,p) pair, its prefix operator and config checks.
package prefix_arith_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic gp_t gp_combine(gp_t hi, gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  function automatic bit is_pow2(int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  function automatic bit group_ok(int g);
    return (g == 1) || (g == 2) || (g == 4) || (g == 8);
  endfunction

  function automatic bit cfg_ok(int w, int g);
    if (!group_ok(g)) return 1'b0;
    if ((w % g) != 0) return 1'b0;
    return is_pow2(w / g) && ((w / g) >= 2);
  endfunction

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_GROUP_SIZE = 8;
  localparam bit DEF_CFG_OK     = cfg_ok(DEF_WIDTH, DEF_GROUP_SIZE);

endpackage

// File: rtl/prefix_sub_group.sv
// One carry-lookahead group: group (g,p) plus local sums
// for carry-in 0 and carry-in 1.
module prefix_sub_group
  import prefix_arith_pkg::*;
#(
  parameter int GS = 8
) (
  input  logic [GS-1:0] a,
  input  logic [GS-1:0] b_inv,
  output gp_t           gp,
  output logic [GS-1:0] sum0,
  output logic [GS-1:0] sum1
);

  logic [GS-1:0] g_bit;
  logic [GS-1:0] p_bit;
  logic [GS-1:0] c0;
  logic [GS-1:0] c1;

  always_comb begin
    g_bit = a & b_inv;
    p_bit = a ^ b_inv;
    c0    = '0;
    c1    = '0;
    c0[0] = 1'b0;
    c1[0] = 1'b1;
    for (int i = 1; i < GS; i++) begin
      c0[i] = g_bit[i-1] | (p_bit[i-1] & c0[i-1]);
      c1[i] = g_bit[i-1] | (p_bit[i-1] & c1[i-1]);
    end
    sum0 = p_bit ^ c0;
    sum1 = p_bit ^ c1;
    gp.g = g_bit[GS-1] | (p_bit[GS-1] & c0[GS-1]);
    gp.p = &p_bit;
  end

endmodule

// File: rtl/prefix_subtractor_pipe.sv
// Two-stage A - B: group lookahead in S1, Brent-Kung group prefix in S2.
// Define PREFIX_SUB_SATURATE_EN to clamp out_diff on signed overflow.
module prefix_subtractor_pipe
  import prefix_arith_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int GROUP_SIZE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             out_overflow
);

  localparam int GS = GROUP_SIZE;
  localparam int NG = WIDTH / GROUP_SIZE;
  localparam int LG = $clog2(NG);

  if (!cfg_ok(WIDTH, GROUP_SIZE)) begin : g_cfg_err
    $error("prefix_subtractor_pipe: illegal WIDTH/GROUP_SIZE");
  end

  logic             accept;
  logic             s2_adv;
  logic [WIDTH-1:0] b_inv;
  gp_t  [NG-1:0]    grp_gp;
  logic [WIDTH-1:0] grp_sum0;
  logic [WIDTH-1:0] grp_sum1;

  logic             s1_valid;
  gp_t  [NG-1:0]    s1_gp;
  logic [WIDTH-1:0] s1_sum0;
  logic [WIDTH-1:0] s1_sum1;
  logic             s1_a_msb;
  logic             s1_b_msb;

  gp_t  [NG-1:0]    pf;
  logic [NG:0]      c;
  logic [WIDTH-1:0] diff_raw;
  logic [WIDTH-1:0] diff_nxt;
  logic             borrow_nxt;
  logic             ovf_nxt;

  assign s2_adv   = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~s1_valid | s2_adv;
  assign accept   = in_valid & in_ready;
  assign b_inv    = ~in_b;

  for (genvar g = 0; g < NG; g++) begin : g_grp
    prefix_sub_group #(
      .GS(GS)
    ) u_grp (
      .a    (in_a[g*GS +: GS]),
      .b_inv(b_inv[g*GS +: GS]),
      .gp   (grp_gp[g]),
      .sum0 (grp_sum0[g*GS +: GS]),
      .sum1 (grp_sum1[g*GS +: GS])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_gp    <= '0;
      s1_sum0  <= '0;
      s1_sum1  <= '0;
      s1_a_msb <= 1'b0;
      s1_b_msb <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_gp    <= grp_gp;
        s1_sum0  <= grp_sum0;
        s1_sum1  <= grp_sum1;
        s1_a_msb <= in_a[WIDTH-1];
        s1_b_msb <= in_b[WIDTH-1];
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Brent-Kung: up-sweep builds power-of-two spans, down-sweep fills gaps.
  always_comb begin
    pf = s1_gp;
    for (int d = 0; d < LG; d++) begin
      for (int i = 0; i < NG; i++) begin
        if (((i + 1) & ((2 << d) - 1)) == 0)
          pf[i] = gp_combine(pf[i], pf[i-(1<<d)]);
      end
    end
    for (int d = LG - 2; d >= 0; d--) begin
      for (int i = 0; i < NG; i++) begin
        if ((i >= (3 << d) - 1) &&
            (((i + 1 - (1 << d)) & ((2 << d) - 1)) == 0))
          pf[i] = gp_combine(pf[i], pf[i-(1<<d)]);
      end
    end
  end

  always_comb begin
    c    = '0;
    c[0] = 1'b1;
    for (int i = 0; i < NG; i++)
      c[i+1] = pf[i].g | pf[i].p;
    diff_raw = '0;
    for (int i = 0; i < NG; i++)
      diff_raw[i*GS +: GS] = c[i] ? s1_sum1[i*GS +: GS]
                                  : s1_sum0[i*GS +: GS];
    borrow_nxt = ~c[NG];
    ovf_nxt    = (s1_a_msb != s1_b_msb) &
                 (diff_raw[WIDTH-1] != s1_a_msb);
`ifdef PREFIX_SUB_SATURATE_EN
    if (ovf_nxt)
      diff_nxt = s1_a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                          : {1'b0, {(WIDTH-1){1'b1}}};
    else
      diff_nxt = diff_raw;
`else
    diff_nxt = diff_raw;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_diff     <= '0;
      out_borrow   <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      if (s2_adv) begin
        out_valid    <= 1'b1;
        out_diff     <= diff_nxt;
        out_borrow   <= borrow_nxt;
        out_overflow <= ovf_nxt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prefix_subtractor_pipe.sv
// Scoreboard bench for prefix_subtractor_pipe (WIDTH=32, GROUP_SIZE=8).
// Driver pushes expected results; a negedge monitor pops on handshake.
module tb_prefix_subtractor_pipe;

  localparam int W = 32;

`ifdef PREFIX_SUB_SATURATE_EN
  localparam logic [W-1:0] EXP_3 = 32'h8000_0000;
  localparam logic [W-1:0] EXP_4 = 32'h7FFF_FFFF;
  localparam logic [W-1:0] EXP_8 = 32'h7FFF_FFFF;
`else
  localparam logic [W-1:0] EXP_3 = 32'h7FFF_FFFF;
  localparam logic [W-1:0] EXP_4 = 32'h8000_0000;
  localparam logic [W-1:0] EXP_8 = 32'h8000_0001;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_diff;
  logic         out_borrow;
  logic         out_overflow;

  prefix_subtractor_pipe #(
    .WIDTH(32),
    .GROUP_SIZE(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_diff    (out_diff),
    .out_borrow  (out_borrow),
    .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    bit           lat;
    int           ecyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic         hold = 1'b0;
  logic [W-1:0] hold_diff;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_diff", out_diff, hold_diff);
      end
      hold      = out_valid & ~out_ready;
      hold_diff = out_diff;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got diff %h, expected no output",
                   out_diff);
        end else begin
          mon_e = sb.pop_front();
          chk("diff", out_diff, mon_e.d);
          chk("borrow", {31'd0, out_borrow}, {31'd0, mon_e.bo});
          chk("overflow", {31'd0, out_overflow}, {31'd0, mon_e.ov});
          if (mon_e.lat)
            chk("latency_cycle", cyc, mon_e.ecyc);
        end
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the accept edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] d, input logic bo,
                      input logic ov, input bit lat);
    int   n;
    exp_t e;
    n        = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: a=%h b=%h not accepted in %0d cycles",
               a, b, n);
      return;
    end
    e.d    = d;
    e.bo   = bo;
    e.ov   = ov;
    e.lat  = lat;
    e.ecyc = cyc + 2;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_diff", out_diff, 32'd0);
    chk("rst_out_borrow", {31'd0, out_borrow}, 32'd0);
    chk("rst_out_overflow", {31'd0, out_overflow}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(32'd5, 32'd3, 32'h0000_0002, 1'b0, 1'b0, 1'b1);
    idle();
    repeat (3) @(posedge clk);
    #1;

    send(32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    send(32'h8000_0000, 32'h0000_0001, EXP_3, 1'b0, 1'b1, 1'b0);
    send(32'h7FFF_FFFF, 32'hFFFF_FFFF, EXP_4, 1'b1, 1'b1, 1'b0);
    send(32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    send(32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    send(32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
    send(32'h0000_0001, 32'h8000_0000, EXP_8, 1'b1, 1'b1, 1'b0);
    send(32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    idle();
    repeat (4) @(posedge clk);
    #1;

    out_ready = 1'b0;
    send(32'd10, 32'd1, 32'd9, 1'b0, 1'b0, 1'b0);
    send(32'h0000_1000, 32'h0000_0001, 32'h0000_0FFF, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    fork
      begin
        send(32'hFFFF_0000, 32'h0001_0000, 32'hFFFE_0000, 1'b0, 1'b0, 1'b0);
        send(32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle();
    repeat (6) @(posedge clk);
    #1;

    out_ready = 1'b0;
    send(32'd7, 32'd2, 32'd5, 1'b0, 1'b0, 1'b0);
    send(32'd9, 32'd4, 32'd5, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_diff", out_diff, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    sb.delete();
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    rst_n     = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("no_stale_out", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    send(32'h0000_0020, 32'h0000_0021, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
    idle();

    n = 0;
    while (sb.size() > 0 && n < 30) begin
      n++;
      @(negedge clk);
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prefix_subtractor_pipe.md
Name: prefix_subtractor_pipe

Overview:
Pipelined two's-complement subtractor. Computes D = A - B as A + ~B + 1 using group carry-lookahead followed by a Brent-Kung group prefix tree, split across two register stages. Takes operands over a valid/ready stream and returns the difference, an unsigned borrow flag and a signed overflow flag over a second valid/ready stream. Serves as the subtract counterpart to the combinational adder on accumulator and bias-correction paths.

Parameters:
WIDTH, 32, operand and difference width; must be a multiple of GROUP_SIZE.
GROUP_SIZE, 8, bits per carry-lookahead group; legal values are 1, 2, 4, 8.
NUM_GROUPS, WIDTH/GROUP_SIZE, derived; must be a power of two and at least 2.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair present
in_ready  out  1  stage 1 can accept
in_a  in  WIDTH  minuend
in_b  in  WIDTH  subtrahend
out_valid  out  1  result present
out_ready  in  1  consumer accepts
out_diff  out  WIDTH  A - B modulo 2^WIDTH
out_borrow  out  1  1 when A < B (unsigned)
out_overflow  out  1  signed overflow of A - B

Behaviour:
- Reset (asynchronous, rst_n=0): s1_valid=0, s2_valid=0, out_valid=0, out_diff=0, out_borrow=0, out_overflow=0. Data registers clear to 0. Any in-flight transaction is dropped.
- Stage 1 (S1), on accept (in_valid & in_ready):
  - form b_inv = ~in_b;
  - per group, compute group generate/propagate (G,P) and two local sums: one assuming group carry-in 0 and one assuming carry-in 1;
  - register the G,P vector, both local-sum vectors, in_a[MSB] and in_b[MSB].
  - Global carry-in is constant 1.
- Stage 2 (S2):
  - the Brent-Kung prefix over the registered (G,P) gives each group's carry-in: c[0]=1, c[i+1]=G[i:0] | P[i:0].
  - Each group selects its local sum with c[i].
  - carry_out = c[NUM_GROUPS]; out_borrow = ~carry_out.
  - out_overflow = (a_msb != b_msb) & (diff_msb != a_msb).
  - Results are registered into the output registers.
- Latency: 2 cycles from accept to out_valid. Throughput is 1 per cycle when out_ready=1.
- Handshake:
  - s2_adv = s1_valid & (~out_valid | out_ready)
  - in_ready = ~s1_valid | s2_adv (combinational through the pipeline, no skid buffer).
  - An output is held stable while out_valid & ~out_ready.
  - An accept and a drain in the same cycle are both honoured.
  - out_valid deasserts only after a handshake with no replacement.
- Ordering: strict FIFO; no reordering and no drops except on reset.
- Boundaries:
  - B=0 gives diff=A, borrow=0.
  - A=B gives diff=0, borrow=0.
  - A borrow ripples across all groups in the single S2 cycle.
  - in_a and in_b are don't-care when in_valid=0.
  - Reset deasserting mid-stream gives empty pipes; in_ready=1 on the first cycle after reset.

Optional Feature:
PREFIX_SUB_SATURATE_EN
- Defined: when out_overflow=1, out_diff is clamped to the signed limit. A_msb=0 gives 0x7FF..F; A_msb=1 gives 0x800..0. out_overflow still reports 1. out_borrow is unchanged, computed from the unclamped result.
- Undefined: out_diff wraps modulo 2^WIDTH. No clamp logic is present.

Decomposition:
- Package prefix_arith_pkg:
  - typedef gp_t, a packed struct {g,p};
  - function gp_combine(hi,lo), returning {hi.g | hi.p&lo.g, hi.p&lo.p};
  - localparam legality checks: NUM_GROUPS power of two, GROUP_SIZE in {1,2,4,8}.
- One sub-module, prefix_sub_group: a GROUP_SIZE slice producing gp_t plus the sum0/sum1 local sums. It is instantiated NUM_GROUPS times in S1.
- The prefix tree and handshake stay in the top module.

Test Plan (WIDTH=32, GROUP_SIZE=8):
- A=5, B=3 -> diff=0x00000002, borrow=0, overflow=0; out_valid exactly 2 cycles after accept.
- A=0x00000000, B=0x00000001 -> diff=0xFFFFFFFF, borrow=1, overflow=0 (borrow through all 4 groups).
- A=0x80000000, B=0x00000001 -> diff=0x7FFFFFFF, overflow=1, borrow=0; with PREFIX_SUB_SATURATE_EN -> diff=0x80000000.
- A=0x7FFFFFFF, B=0xFFFFFFFF -> diff=0x80000000, overflow=1, borrow=1; with PREFIX_SUB_SATURATE_EN -> diff=0x7FFFFFFF.
- Backpressure: 4 back-to-back inputs with out_ready=0 for 6 cycles -> in_ready=0 after 2 accepts; out_diff stable; all 4 results delivered in order once out_ready=1.
- Reset mid-stream: assert rst_n=0 with 2 in flight -> out_valid=0 immediately (asynchronous); no stale result after release; next input yields a correct result 2 cycles later.
